// File: rtl/mod3.sv
// Debounced push-button press counter, modulo 3.
// btn is synchronized, debounced, rising-edge detected, and counted 0->1->2->0.
module mod3 #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       set,
  output logic [1:0] count
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   acc;
  logic                   acc_q;
  logic [CW-1:0]          db_cnt;
  logic                   press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // db_cnt counts edges the synced level has disagreed with acc, minus one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= 1'b0;
      db_cnt <= '0;
    end else if (synced == acc) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      acc    <= synced;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= 1'b0;
    else      acc_q <= acc;
  end

  assign press = acc & ~acc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     count <= 2'd0;
    else if (count == 2'd3 | set) count <= 2'd0;
    else if (press)               count <= (count == 2'd2) ? 2'd0 : count + 2'd1;
  end

endmodule

// File: tb/tb_mod3.sv
// Randomized and directed bench for mod3 against a sample-window reference model.
module tb_mod3;
  localparam int S = 2;
  localparam int D = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn = 1'b0;
  logic       set = 1'b0;
  logic [1:0] count;

  mod3 #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .btn(btn), .set(set), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: hist[i] is the btn sample taken i+1 edges ago (zero before reset release).
  bit hist[64];
  bit acc_m;
  bit rose_m;
  int cnt_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) hist[i] = 1'b0;
    acc_m  = 1'b0;
    rose_m = 1'b0;
    cnt_m  = 0;
  endtask

  // One clock edge: update model from the inputs seen at the edge, then compare.
  task automatic tick();
    bit all_diff;
    @(posedge clk);
    if (rst) begin
      if (set)         cnt_m = 0;
      else if (rose_m) cnt_m = (cnt_m + 1) % 3;
      // The debouncer sees the sample taken S edges ago; accept after D disagreeing in a row.
      all_diff = 1'b1;
      for (int j = 0; j < D; j++)
        if (hist[S-1+j] == acc_m) all_diff = 1'b0;
      rose_m = 1'b0;
      if (all_diff) begin
        acc_m  = ~acc_m;
        rose_m = acc_m;
      end
      for (int i = 63; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = btn;
    end
    #1 check("count_vs_model", count, cnt_m);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Ticks until count differs from prev; n = tick index of the change (21 if none).
  task automatic wait_change(input logic [1:0] prev, output int n);
    n = 21;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (count != prev) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic press(input int hi, input int lo);
    btn = 1'b1; ticks(hi);
    btn = 1'b0; ticks(lo);
  endtask

  task automatic async_reset(input int cycles, input string name);
    #2 rst = 1'b0;
    model_reset();
    #1 check(name, count, 0);
    for (int i = 0; i < cycles; i++) begin
      btn = 1'($urandom_range(0, 1));
      tick();
      check({name, "_held"}, count, 0);
    end
  endtask

  int n;

  initial begin
    model_reset();
    #7 check("reset_state", count, 0);
    #6 rst = 1'b1;
    ticks(3);

    // Three clean presses, 4-edge latency each.
    for (int p = 0; p < 3; p++) begin
      btn = 1'b1;
      wait_change(count, n);
      check("press_latency", n - 1, 4);
      check("press_value", count, (p + 1) % 3);
      ticks(10 - n);
      btn = 1'b0; ticks(10);
    end

    // Bounce: five 1-cycle glitches, then a solid press.
    for (int i = 0; i < 5; i++) begin
      btn = 1'b1; tick();
      btn = 1'b0; tick();
    end
    check("bounce_no_count", count, 0);
    btn = 1'b1;
    wait_change(count, n);
    check("bounce_latency", n - 1, 4);
    check("bounce_value", count, 1);
    ticks(9);
    btn = 1'b0; ticks(10);
    check("bounce_once", count, 1);

    // Hold for 50 cycles from 0: one event only.
    set = 1'b1; tick(); set = 1'b0;
    check("set_clear", count, 0);
    btn = 1'b1; ticks(50);
    check("hold_once", count, 1);
    btn = 1'b0; ticks(10);
    press(10, 10);
    check("hold_repress", count, 2);

    // Asynchronous reset from count=2.
    async_reset(3, "async_from_2");
    btn = 1'b0;
    rst = 1'b1;
    ticks(3);
    press(10, 10);
    press(10, 10);
    check("pre_set_value", count, 2);

    // Set coinciding with press event: press is discarded.
    set = 1'b1; tick(); set = 1'b0;
    check("set_from_2", count, 0);
    btn = 1'b1; ticks(4);
    set = 1'b1; tick(); set = 1'b0;
    check("set_wins_press", count, 0);
    ticks(10);
    check("set_wins_no_late", count, 0);
    btn = 1'b0; ticks(10);

    // Reset mid-press with button held across release.
    press(10, 10);
    check("pre_rst_value", count, 1);
    btn = 1'b1; ticks(2);
    async_reset(2, "rst_mid_press");
    btn = 1'b1;
    rst = 1'b1;
    wait_change(2'd0, n);
    check("rst_release_latency", n - 1, 4);
    check("rst_release_value", count, 1);
    btn = 1'b0; ticks(10);

    // Random runs of btn, occasional set and reset.
    for (int r = 0; r < 600; r++) begin
      btn = 1'($urandom_range(0, 1));
      for (int i = $urandom_range(1, 8); i > 0; i--) begin
        set = ($urandom_range(0, 15) == 0);
        tick();
      end
      set = 1'b0;
      if ($urandom_range(0, 99) == 0) begin
        async_reset($urandom_range(1, 3), "rand_reset");
        rst = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at %0t: got running, expected finished", $time);
    $fatal(1, "timeout");
  end
endmodule
